dmem_responder: RTL and testbench

Data-memory responder that sits on the far side of the pipeline's memory stage and answers its load/store requests. It provides a word-addressed, byte-enabled RAM behind a valid/ready request channel and a valid/ready response channel. Response latency is configurable so memory-stage stall handling can be exercised. Only one request is outstanding at a time.

---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the memory stage (master) and the data
//   memory responder (slave).
//
//   Request channel  : req_valid, req_ready, req_write, req_addr[31:0],
//                      req_wdata[31:0], req_be[3:0]
//   Response channel : rsp_valid, rsp_ready, rsp_rdata[31:0], rsp_err
//
//   master modport : drives the request fields and rsp_ready
//   slave  modport : drives req_ready and the response fields
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Word-addressed, byte-enabled data RAM answering one load/store request at
//   a time with a configurable response latency (1..15 cycles).
//
//   Ports
//     clk       : rising-edge clock
//     rst       : asynchronous active-high reset (control and response regs;
//                 RAM contents are not reset)
//     bus       : dmem_responder_if.slave (request + response channels)
//     rd_count  : accepted non-error loads, saturating   (optional)
//     wr_count  : accepted non-error stores, saturating  (optional)
//
//   Build option
//     DMEM_ACCESS_COUNT_EN : when defined, adds rd_count/wr_count and the
//                            counters behind them.
//
//   Parameters
//     DEPTH_WORDS : RAM size in 32-bit words, word index = req_addr[31:2]
//     LATENCY     : accept edge to rsp_valid distance in cycles
//     CNT_W       : width of the optional access counters
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [3:0]  waitCnt;
  logic [3:0]  waitCntNext;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] wordIdx_p0;
  logic [AW-1:0] ramIdx_p0;
  logic        err_p0;
  logic        accept_p0;
  logic        rspHs;

  logic [31:0] rspData_p1;
  logic        rspErr_p1;

  // ---- stage p0: request decode at the accept edge ----
  // The index compare uses the full 30-bit word index so high addresses
  // never alias onto low RAM words.
  assign wordIdx_p0 = {2'b00, bus.req_addr[31:2]};
  assign ramIdx_p0  = wordIdx_p0[AW-1:0];
  assign err_p0     = (bus.req_addr[1:0] != 2'b00) ||
                      (wordIdx_p0 >= 32'(DEPTH_WORDS));
  // Accept is derived from the state rather than req_ready to keep the
  // handshake free of a combinational loop through the FSM outputs; rst
  // blocks a RAM write on an edge that lands while reset is held.
  assign accept_p0  = bus.req_valid && (state == IDLE) && !rst;
  assign rspHs      = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept_p0) begin
          if (LATENCY <= 1) begin
            stateNext = RESP;
          end else begin
            stateNext   = WAIT;
            waitCntNext = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          stateNext = RESP;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stores commit at their accept edge so any later load sees them, even if
  // the transaction is later aborted by reset.
  always_ff @(posedge clk) begin
    if (accept_p0 && bus.req_write && !err_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_be[b]) begin
          mem[ramIdx_p0][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---- stage p1: response register, held until the response handshake ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspData_p1 <= 32'd0;
      rspErr_p1  <= 1'b0;
    end else if (accept_p0) begin
      rspErr_p1  <= err_p0;
      rspData_p1 <= (err_p0 || bus.req_write) ? 32'd0 : mem[ramIdx_p0];
    end else if (rspHs) begin
      rspData_p1 <= 32'd0;
      rspErr_p1  <= 1'b0;
    end
  end

  assign bus.rsp_rdata = rspData_p1;
  assign bus.rsp_err   = rspErr_p1;

`ifdef DMEM_ACCESS_COUNT_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept_p0 && !err_p0) begin
      if (bus.req_write) begin
        wr_count <= satInc(wr_count);
      end else begin
        rd_count <= satInc(rd_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  // DUT 0: LATENCY=1, DUT 1: LATENCY=2, DUT 2: LATENCY=4
  function automatic int latOf(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;

  logic        reqValid  [NDUT];
  logic        reqWrite  [NDUT];
  logic [31:0] reqAddr   [NDUT];
  logic [31:0] reqWdata  [NDUT];
  logic [3:0]  reqBe     [NDUT];
  logic        rspReady  [NDUT];
  logic        reqReady  [NDUT];
  logic        rspValid  [NDUT];
  logic [31:0] rspRdata  [NDUT];
  logic        rspErr    [NDUT];
`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rdCount   [NDUT];
  logic [15:0] wrCount   [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    dmem_responder_if ifc ();
    assign ifc.req_valid = reqValid[g];
    assign ifc.req_write = reqWrite[g];
    assign ifc.req_addr  = reqAddr[g];
    assign ifc.req_wdata = reqWdata[g];
    assign ifc.req_be    = reqBe[g];
    assign ifc.rsp_ready = rspReady[g];
    assign reqReady[g]   = ifc.req_ready;
    assign rspValid[g]   = ifc.rsp_valid;
    assign rspRdata[g]   = ifc.rsp_rdata;
    assign rspErr[g]     = ifc.rsp_err;

    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (latOf(g)),
      .CNT_W      (16)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (ifc)
`ifdef DMEM_ACCESS_COUNT_EN
      ,
      .rd_count(rdCount[g]),
      .wr_count(wrCount[g])
`endif
    );
  end

  // Reference model: plain word array per DUT plus expected access counts.
  logic [31:0] model [NDUT][DEPTH];
  int          rdExp [NDUT];
  int          wrExp [NDUT];

  int nChecks;
  int nFails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chkCounters(input int d);
`ifdef DMEM_ACCESS_COUNT_EN
    chk("rd_count", 32'(rdCount[d]), rdExp[d]);
    chk("wr_count", 32'(wrCount[d]), wrExp[d]);
`else
    if (d < 0) $display("unreachable");
`endif
  endtask

  function automatic bit isErr(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  // Runs one full transaction on DUT d starting from a negedge in IDLE and
  // ends on the negedge after the response handshake.
  task automatic transact(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int hold, output logic [31:0] rdata);
    bit          expErr;
    logic [31:0] expData;
    int          lat;
    bit          seen;
    int          w;

    chk("req_ready_idle", 32'(reqReady[d]), 1);
    reqValid[d] = 1'b1;
    reqWrite[d] = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqBe[d]    = be;
    rspReady[d] = (hold == 0);

    expErr  = isErr(addr);
    expData = 32'd0;
    w       = int'(addr / 4);
    if (!expErr) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[d][w][8*b +: 8] = wdata[8*b +: 8];
        wrExp[d]++;
      end else begin
        expData = model[d][w];
        rdExp[d]++;
      end
    end

    @(posedge clk);
    #1;
    // Busy-time noise on the request bus; the responder must ignore it.
    reqValid[d] = 1'b1;
    reqWrite[d] = 1'($urandom);
    reqAddr[d]  = $urandom & 32'h0000_03FC;
    reqWdata[d] = $urandom;
    reqBe[d]    = 4'($urandom);

    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rspValid[d]) seen = 1'b1;
      else chk("req_ready_wait", 32'(reqReady[d]), 0);
    end
    if (!seen) begin
      chk("rsp_timeout", 0, 1);
      reqValid[d] = 1'b0;
      rspReady[d] = 1'b1;
      rdata = 32'd0;
      return;
    end

    chk("latency", lat, latOf(d));
    chk("rsp_err", 32'(rspErr[d]), 32'(expErr));
    chk("rsp_rdata", rspRdata[d], expData);
    chk("req_ready_resp", 32'(reqReady[d]), 0);
    rdata = rspRdata[d];

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rspValid[d]), 1);
      chk("hold_err", 32'(rspErr[d]), 32'(expErr));
      chk("hold_rdata", rspRdata[d], expData);
      chk("hold_req_ready", 32'(reqReady[d]), 0);
    end

    reqValid[d] = 1'b0;
    rspReady[d] = 1'b1;
    @(negedge clk);
    chk("idle_valid", 32'(rspValid[d]), 0);
    chk("idle_req_ready", 32'(reqReady[d]), 1);
    chk("idle_rdata", rspRdata[d], 0);
    chk("idle_err", 32'(rspErr[d]), 0);
    chkCounters(d);
  endtask

  task automatic clearExpCounts();
    for (int d = 0; d < NDUT; d++) begin
      rdExp[d] = 0;
      wrExp[d] = 0;
    end
  endtask

  task automatic chkIdleAll(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_req_ready"}, 32'(reqReady[d]), 1);
      chk({tag, "_rsp_valid"}, 32'(rspValid[d]), 0);
      chk({tag, "_rsp_rdata"}, rspRdata[d], 0);
      chk({tag, "_rsp_err"}, 32'(rspErr[d]), 0);
      chkCounters(d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] dat;
    int          d;
    int          r;

    nChecks = 0;
    nFails  = 0;
    rst     = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      reqValid[i] = 1'b0;
      reqWrite[i] = 1'b0;
      reqAddr[i]  = 32'd0;
      reqWdata[i] = 32'd0;
      reqBe[i]    = 4'd0;
      rspReady[i] = 1'b1;
    end
    clearExpCounts();

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    chkIdleAll("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chkIdleAll("rst_done");

    // Fill every word of every DUT so the model is fully known
    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < DEPTH; w++)
        transact(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd);

    // Store/load round trip
    transact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    chk("rt_store_rdata", rd, 32'h0);
    transact(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    chk("rt_load", rd, 32'hDEADBEEF);

    // Byte-enable merge
    transact(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    transact(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    transact(1, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd);
    chk("be_merge", rd, 32'h11BB33DD);

    // be=0 store is a no-op without error
    transact(1, 1'b1, 32'h20, 32'h55555555, 4'h0, 0, rd);
    transact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    chk("be_zero_noop", rd, 32'h11BB33DD);

    // Errors: misaligned load, out-of-range store, word 0 untouched
    transact(1, 1'b0, 32'h13, 32'h0, 4'hF, 0, rd);
    dat = model[1][0];
    transact(1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd);
    transact(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd);
    chk("oor_no_wrap", rd, dat);
    transact(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, rd);
    transact(1, 1'b0, 32'h3FC, 32'h0, 4'hF, 0, rd);

    // Backpressure at LATENCY=2 and LATENCY=1
    transact(1, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd);
    transact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd);
    transact(0, 1'b1, 32'h44, 32'h01020304, 4'hF, 0, rd);
    transact(0, 1'b0, 32'h44, 32'h0, 4'hF, 0, rd);
    chk("lat1_load", rd, 32'h01020304);

    // Asynchronous reset while a response is pending (LATENCY=4)
    reqValid[2] = 1'b1;
    reqWrite[2] = 1'b0;
    reqAddr[2]  = 32'h40;
    reqBe[2]    = 4'hF;
    rspReady[2] = 1'b0;
    @(posedge clk);
    #1;
    reqValid[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("async_pre_valid", 32'(rspValid[2]), 1);
    #2;
    rst = 1'b1;
    #1;
    clearExpCounts();
    chk("async_rsp_valid", 32'(rspValid[2]), 0);
    chk("async_req_ready", 32'(reqReady[2]), 1);
    chk("async_rsp_rdata", rspRdata[2], 0);
    chk("async_rsp_err", 32'(rspErr[2]), 0);
    chkCounters(2);
    @(negedge clk);
    rst = 1'b0;
    rspReady[2] = 1'b1;

    // Reset during WAIT after a store: response dropped, store kept
    transact(2, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd);
    reqValid[2] = 1'b1;
    reqWrite[2] = 1'b1;
    reqAddr[2]  = 32'h8;
    reqWdata[2] = 32'h600DD00D;
    reqBe[2]    = 4'hF;
    @(posedge clk);
    #1;
    reqValid[2]  = 1'b0;
    model[2][2]  = 32'h600DD00D;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearExpCounts();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_wait_no_rsp", 32'(rspValid[2]), 0);
      chk("rst_wait_req_ready", 32'(reqReady[2]), 1);
    end
    chkCounters(2);
    transact(2, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd);
    chk("rst_store_kept", rd, 32'h600DD00D);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      d = $urandom_range(0, NDUT - 1);
      r = $urandom_range(0, 9);
      case (r)
        0:       addr = ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
        1:       addr = 32'($urandom_range(DEPTH, 4000)) * 4;
        2:       addr = 32'h3FC;
        3:       addr = {$urandom} | 32'h8000_0000;
        default: addr = $urandom & 32'h3FC;
      endcase
      transact(d, 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
